// File: rtl/seq_pattern_gen_if.sv
// Bus bundle between a serial pattern transmitter and whatever drives its start/pattern/length.
// master = requesting side, slave = the transmitter.
interface seq_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] length;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, length,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, pattern, length,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter: loads pattern/length on start, shifts MSB-first, then pulses done.
// Optional even-parity trailer bit when SEQ_PATTERN_GEN_PARITY_EN is defined.
module seq_pattern_gen #(
    parameter int   WIDTH      = 8,
    parameter int   LEN_W      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic            clock,
    input logic            reset,
    seq_pattern_gen_if.slave bus
);

`ifdef SEQ_PATTERN_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PAR, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
`endif

    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             out_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             done_r;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    logic             parity_r;
`endif

    logic [LEN_W-1:0] len_c;
    logic [WIDTH-1:0] aligned;

    // Clamp the length and left-align the live bits so the MSB is always the next bit out.
    always_comb begin
        len_c   = (bus.length > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.length;
        aligned = bus.pattern << (WIDTH - int'(len_c));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            out_r       <= IDLE_LEVEL;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, FIN: begin
                    state       <= IDLE;
                    out_r       <= IDLE_LEVEL;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    if (bus.start) begin
                        shreg <= aligned << 1;
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                        parity_r <= ^aligned;
`endif
                        if (len_c != '0) begin
                            state       <= SEND;
                            cnt         <= len_c - LEN_W'(1);
                            out_r       <= aligned[WIDTH-1];
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
                        end else begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                            state       <= PAR;
                            out_r       <= 1'b0;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b1;
`else
                            state       <= FIN;
                            done_r      <= 1'b1;
`endif
                        end
                    end
                end
                SEND: begin
                    if (cnt == '0) begin
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                        state <= PAR;
                        out_r <= parity_r;
`else
                        state       <= FIN;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b0;
                        out_r       <= IDLE_LEVEL;
`endif
                    end else begin
                        out_r <= shreg[WIDTH-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt - LEN_W'(1);
                    end
                end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
                PAR: begin
                    state       <= FIN;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_r       <= IDLE_LEVEL;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule
